serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; legal range 2..16.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a subtraction; sampled on the rising edge of CLK.
REQ-005 A  input  WIDTH  minuend; sampled when start is accepted.
REQ-006 B  input  WIDTH  subtrahend; sampled when start is accepted.
REQ-007 B_in  input  1  borrow-in; sampled when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse marking that the result is valid.
REQ-010 D  output  WIDTH  difference A - B - B_in, modulo 2^WIDTH.
REQ-011 B_out  output  1  borrow-out; 1 when A < B + B_in (unsigned).

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, start=1 SHALL capture A, B and B_in, clear the bit counter, and move the FSM to RUN.
REQ-014 In RUN, each edge SHALL process one bit, LSB first:
- d = a ^ b ^ br
- br' = (~a & b) | (~a & br) | (b & br)
- d is shifted into an internal result register.
REQ-015 After exactly WIDTH RUN edges, the FSM SHALL enter DONE; on that same edge D and B_out SHALL be loaded from the internal register and the final borrow.
REQ-016 Latency: if start is accepted at edge k, done SHALL be high for the cycle following edge k+WIDTH.
REQ-017 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-018 done SHALL be 1 exactly while the FSM is in DONE, which lasts one cycle.
REQ-019 From DONE with start=0, the FSM SHALL return to IDLE.
REQ-020 From DONE with start=1, a new operation SHALL begin (back-to-back, no idle cycle).
REQ-021 start asserted while in RUN SHALL be ignored; captured operands and progress are unaffected.
REQ-022 D and B_out SHALL hold their last result until the next completion; they never show partial results.
REQ-023 Changes on A, B and B_in after acceptance SHALL have no effect on the running operation.

Reset
REQ-024 RST_n=0 SHALL immediately, without waiting for a clock edge, force:
- FSM to IDLE
- busy=0, done=0, D=0, B_out=0
- internal registers cleared.
REQ-025 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-026 The first start after reset release SHALL be accepted normally.

Configuration
REQ-027 Macro SERIAL_SUB_OVF_EN:
- When defined: add output port V (1 bit), the two's-complement overflow of the operation, computed as borrow into the MSB XOR borrow out of the MSB. V is loaded together with D, holds like D, and resets to 0.
- When undefined: port V and its logic SHALL NOT exist; all other behaviour is identical.

Verification
REQ-028 A=9, B=5, B_in=0, start pulse -> busy high for 4 cycles, then done pulse with D=4, B_out=0.
REQ-029 A=3, B=5, B_in=0 -> D=14, B_out=1. Then A=0, B=0, B_in=1 -> D=15, B_out=1.
REQ-030 Back-to-back: start held high through DONE with A=15, B=15, B_in=0 for the second operation -> second done exactly 5 cycles after the first, D=0, B_out=0. start pulses during RUN -> ignored.
REQ-031 RST_n pulled low 2 cycles into RUN -> outputs 0 immediately; no done after release; next operation A=6, B=2 -> D=4.
REQ-032 With SERIAL_SUB_OVF_EN defined:
- A=8, B=1 -> D=7, V=1
- A=7, B=15 -> D=8, V=1
- A=5, B=3 -> D=2, V=0.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - B_in, one bit per clock, LSB first.
// Optional SERIAL_SUB_OVF_EN adds a two's-complement overflow output V.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, d_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg, bout_reg;
  logic             load, step, last;
  logic             d_bit, br_next;
  logic [WIDTH-1:0] res_next;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One full-subtractor slice on the current LSBs of the shifted operands
  assign last     = (cnt_reg == LAST);
  assign d_bit    = a_reg[0] ^ b_reg[0] ^ br_reg;
  assign br_next  = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & br_reg) | (b_reg[0] & br_reg);
  assign res_next = {d_bit, res_reg[WIDTH-1:1]};

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      br_reg   <= 1'b0;
      cnt_reg  <= '0;
      d_reg    <= '0;
      bout_reg <= 1'b0;
    end else if (load) begin
      a_reg   <= A;
      b_reg   <= B;
      br_reg  <= B_in;
      res_reg <= '0;
      cnt_reg <= '0;
    end else if (step) begin
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      br_reg  <= br_next;
      res_reg <= res_next;
      cnt_reg <= cnt_reg + 1'b1;
      // Visible outputs only change on the final bit, never mid-operation
      if (last) begin
        d_reg    <= res_next;
        bout_reg <= br_next;
      end
    end
  end

  assign D     = d_reg;
  assign B_out = bout_reg;

`ifdef SERIAL_SUB_OVF_EN
  logic v_reg;

  // On the final step br_reg is the borrow into the MSB, br_next the borrow out
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)             v_reg <= 1'b0;
    else if (step && last)  v_reg <= br_reg ^ br_next;
  end

  assign V = v_reg;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: stimulus pushes expected results, a monitor
// pops and compares on every done pulse (value, borrow, overflow and timing).
module tb_serial_sub;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         B_in;
  logic         busy, done;
  logic [W-1:0] D;
  logic         B_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         V;
`endif

  serial_sub #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .start (start),
    .A     (A),
    .B     (B),
    .B_in  (B_in),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .B_out (B_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .V     (V)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin
    exp_t e;
    if (RST_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("D", int'(D), int'(e.d));
        check("B_out", int'(B_out), int'(e.bo));
        check("done_cycle", cyc, e.cyc);
`ifdef SERIAL_SUB_OVF_EN
        check("V", int'(V), int'(e.v));
`endif
        $display("done @%0d: D=%0d B_out=%0d (expected D=%0d B_out=%0d)",
                 cyc, D, B_out, e.d, e.bo);
      end
    end
  end

  // Drive one start pulse at a negedge; operands are scrambled afterwards
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input logic [W-1:0] ed, input logic eb, input logic ev);
    A = a; B = b; B_in = bin; start = 1'b1;
    sb.push_back(exp_t'{ed, eb, ev, cyc + 1 + W});
    @(negedge CLK);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); B_in = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input logic ev);
    int nb = 0;
    issue(a, b, bin, ed, eb, ev);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      if (busy) nb++;
      @(negedge CLK);
    end
    check("busy_cycles", nb, W);
    @(negedge CLK);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    RST_n = 1'b0; start = 1'b0; A = '0; B = '0; B_in = 1'b0;
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_D", int'(D), 0);
    check("rst_B_out", int'(B_out), 0);
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);

    // Basic operations (expected V from signed range of A - B - B_in)
    run_op(4'd9,  4'd5,  1'b0, 4'd4,  1'b0, 1'b1);
    run_op(4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0);
    run_op(4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0);
    run_op(4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1);
    run_op(4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1);
    run_op(4'd5,  4'd3,  1'b0, 4'd2,  1'b0, 1'b0);

    // Back-to-back: start held through RUN and DONE, second operands 15 - 15
    A = 4'd10; B = 4'd3; B_in = 1'b1; start = 1'b1;
    sb.push_back(exp_t'{4'd6, 1'b0, 1'b1, cyc + 1 + W});
    sb.push_back(exp_t'{4'd0, 1'b0, 1'b0, cyc + 1 + W + 1 + W});
    @(negedge CLK);
    A = 4'd15; B = 4'd15; B_in = 1'b0;
    repeat (W + 1) @(negedge CLK);
    start = 1'b0; A = 4'd1; B = 4'd9;
    drain();

    // Start pulse during RUN must be ignored
    @(negedge CLK);
    issue(4'd12, 4'd7, 1'b0, 4'd5, 1'b0, 1'b1);
    @(negedge CLK);
    A = 4'd1; B = 4'd2; B_in = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    drain();
    repeat (3) @(negedge CLK);

    // Reset two cycles into RUN: aborted, outputs cleared asynchronously
    A = 4'd13; B = 4'd2; B_in = 1'b0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_D", int'(D), 0);
    check("async_rst_B_out", int'(B_out), 0);
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (8) @(negedge CLK);
    run_op(4'd6, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
